// File: rtl/user_pixel_rom.sv
// Pixel image store: CPU loads a 256-byte image over OBI, the edge-detection fetch master reads
// single pixels with a fixed latency. Define USER_PIXEL_ROM_FETCH_CNT_EN to build FETCH_CNT (0x104).
package user_pixel_rom_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;
endpackage

module user_pixel_rom #(
  parameter type             obi_req_t   = user_pixel_rom_pkg::obi_req_t,
  parameter type             obi_rsp_t   = user_pixel_rom_pkg::obi_rsp_t,
  parameter int unsigned     ImgWidth    = 16,
  parameter int unsigned     ImgHeight   = 16,
  parameter int unsigned     Latency     = 1,
  parameter logic [7:0]      BorderValue = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  input  logic        rom_req_i,
  input  logic [15:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        rom_valid_o
);

  localparam int unsigned NumPixels = ImgWidth * ImgHeight;
  localparam logic [1:0]  WaitInit  = (Latency >= 2) ? 2'(Latency - 2) : 2'd0;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_RESP
  } fetch_state_e;

  logic [7:0]   mem_q [256];
  logic [3:0]   mem_we;
  logic [5:0]   pix_word;
  logic [8:0]   obi_off;

  logic         lock_q, lock_d;
  logic         rvalid_q, rvalid_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         err_q, err_d;
  logic [31:0]  fetch_cnt_rd;

  fetch_state_e state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [7:0]   pix_q, pix_d;

  logic         unused_addr;

  assign obi_off     = obi_req_i.addr[8:0];
  assign pix_word    = obi_off[7:2];
  assign unused_addr = ^obi_req_i.addr[31:9];

  // ---------------------------------------------------------------------------
  // OBI register/memory decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    lock_d   = lock_q;
    rvalid_d = obi_req_i.req;
    rdata_d  = '0;
    err_d    = 1'b0;
    mem_we   = '0;
    if (obi_req_i.req) begin
      if (!obi_off[8]) begin
        if (obi_req_i.we) begin
          if (lock_q) err_d  = 1'b1;
          else        mem_we = obi_req_i.be;
        end else begin
          rdata_d = {mem_q[{pix_word, 2'd3}], mem_q[{pix_word, 2'd2}],
                     mem_q[{pix_word, 2'd1}], mem_q[{pix_word, 2'd0}]};
        end
      end else if (obi_off == 9'h100) begin
        if (obi_req_i.we) begin
          if (obi_req_i.be[0]) lock_d = obi_req_i.wdata[0];
        end else begin
          rdata_d = {31'd0, lock_q};
        end
      end else if (obi_off == 9'h104) begin
        if (!obi_req_i.we) rdata_d = fetch_cnt_rd;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the pixel array is flops, not a RAM macro, because reset must clear
  // every byte to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem_q[{pix_word, 2'(b)}] <= obi_req_i.wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    unique case (state_q)
      FETCH_IDLE: begin
        if (rom_req_i) begin
          // mem_q is read before this edge's OBI write lands: pre-write value wins.
          pix_d = (32'(rom_addr_i) >= NumPixels) ? BorderValue : mem_q[rom_addr_i[7:0]];
          if (Latency == 1) begin
            state_d = FETCH_RESP;
          end else begin
            state_d = FETCH_WAIT;
            cnt_d   = WaitInit;
          end
        end
      end
      FETCH_WAIT: begin
        if (cnt_q == 2'd0) state_d = FETCH_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      FETCH_RESP: state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH_IDLE;
      cnt_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
    end
  end

  assign rom_valid_o = (state_q == FETCH_RESP);
  assign rom_data_o  = rom_valid_o ? {24'd0, pix_q} : 32'd0;

`ifdef USER_PIXEL_ROM_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (state_q == FETCH_RESP) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) fetch_cnt_q <= '0;
    else       fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt_rd = fetch_cnt_q;
`else
  assign fetch_cnt_rd = '0;
`endif

endmodule

// File: tb/tb_user_pixel_rom.sv
// Scoreboard bench for user_pixel_rom: three instances (Latency 1, 3, 4) share one OBI bus
// so the same image is visible at every latency; each has its own fetch port.
module tb_user_pixel_rom;
  import user_pixel_rom_pkg::*;

  logic        clk;
  logic        rst_i;
  obi_req_t    obi_req;
  obi_rsp_t    rsp0, rsp1, rsp2;
  logic        rom_req   [3];
  logic [15:0] rom_addr  [3];
  logic [31:0] rom_data  [3];
  logic        rom_valid [3];

  int          tests  = 0;
  int          failed = 0;

  logic [7:0]  shadow [256];
  logic        lock_model;
  logic [31:0] fcnt_model;
  logic [31:0] fetch_q [$];
  logic [32:0] obi_q   [$];

  user_pixel_rom #(.Latency(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst_i), .obi_req_i(obi_req), .obi_rsp_o(rsp0),
    .rom_req_i(rom_req[0]), .rom_addr_i(rom_addr[0]),
    .rom_data_o(rom_data[0]), .rom_valid_o(rom_valid[0])
  );

  user_pixel_rom #(.Latency(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst_i), .obi_req_i(obi_req), .obi_rsp_o(rsp1),
    .rom_req_i(rom_req[1]), .rom_addr_i(rom_addr[1]),
    .rom_data_o(rom_data[1]), .rom_valid_o(rom_valid[1])
  );

  user_pixel_rom #(.Latency(4)) u_dut_l4 (
    .clk_i(clk), .rst_i(rst_i), .obi_req_i(obi_req), .obi_rsp_o(rsp2),
    .rom_req_i(rom_req[2]), .rom_addr_i(rom_addr[2]),
    .rom_data_o(rom_data[2]), .rom_valid_o(rom_valid[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    lock_model = 1'b0;
    fcnt_model = 32'd0;
  endtask

  function automatic logic [7:0] model_pixel(input logic [15:0] a);
    if (a >= 16'd256) return 8'h00;
    return shadow[a[7:0]];
  endfunction

  function automatic logic [31:0] cnt_expect();
`ifdef USER_PIXEL_ROM_FETCH_CNT_EN
    return fcnt_model;
`else
    return 32'd0;
`endif
  endfunction

  // One OBI transfer on the shared bus, checked against instance 0's response.
  task automatic obi_xfer(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input string name);
    logic [8:0]  off;
    logic [5:0]  w;
    logic [32:0] exp_v, got_v;
    off   = a[8:0];
    w     = off[7:2];
    exp_v = '0;
    if (!off[8]) begin
      if (we) exp_v[32] = lock_model;
      else exp_v[31:0] = {shadow[{w, 2'd3}], shadow[{w, 2'd2}], shadow[{w, 2'd1}], shadow[{w, 2'd0}]};
    end else if (off == 9'h100) begin
      if (!we) exp_v[31:0] = {31'd0, lock_model};
    end else if (off == 9'h104) begin
      if (!we) exp_v[31:0] = cnt_expect();
    end else begin
      exp_v[32] = 1'b1;
    end
    obi_q.push_back(exp_v);

    obi_req.req   = 1'b1;
    obi_req.we    = we;
    obi_req.be    = be;
    obi_req.addr  = a;
    obi_req.wdata = wd;
    #1;
    tests++;
    if (rsp0.gnt !== 1'b1) begin
      failed++;
      $display("FAIL %s gnt: got %b exp 1", name, rsp0.gnt);
    end
    @(posedge clk); #1;
    obi_req.req = 1'b0;
    obi_req.we  = 1'b0;
    if (we) begin
      if (!off[8] && !lock_model) begin
        for (int b = 0; b < 4; b++) if (be[b]) shadow[{w, 2'(b)}] = wd[8*b +: 8];
      end else if (off == 9'h100 && be[0]) begin
        lock_model = wd[0];
      end
    end
    got_v = {rsp0.err, rsp0.rdata};
    exp_v = obi_q.pop_front();
    tests++;
    if (rsp0.rvalid !== 1'b1) begin
      failed++;
      $display("FAIL %s rvalid: got %b exp 1", name, rsp0.rvalid);
    end
    tests++;
    if (got_v !== exp_v) begin
      failed++;
      $display("FAIL %s rsp: got err=%b rdata=%h exp err=%b rdata=%h",
               name, got_v[32], got_v[31:0], exp_v[32], exp_v[31:0]);
    end
  endtask

  // Drives a fetch on instance k and waits (bounded) for its valid pulse.
  // exp_cyc counts cycles from the call to the pulse; pulse=1 drops req after one cycle.
  task automatic do_fetch(input int k, input logic [15:0] a, input int exp_cyc,
                          input bit pulse, input string name);
    logic [31:0] exp_v;
    bit          got;
    int          c;
    fetch_q.push_back({24'd0, model_pixel(a)});
    rom_req[k]  = 1'b1;
    rom_addr[k] = a;
    got = 1'b0;
    c   = 0;
    while (!got && c < 12) begin
      step();
      c++;
      if (pulse) rom_req[k] = 1'b0;
      if (rom_valid[k] === 1'b1) got = 1'b1;
    end
    exp_v = fetch_q.pop_front();
    tests++;
    if (!got) begin
      failed++;
      $display("FAIL %s: no rom_valid within %0d cycles", name, c);
    end else begin
      tests++;
      if (rom_data[k] !== exp_v) begin
        failed++;
        $display("FAIL %s data: got %h exp %h", name, rom_data[k], exp_v);
      end
      tests++;
      if (c != exp_cyc) begin
        failed++;
        $display("FAIL %s latency: got %0d cycles exp %0d", name, c, exp_cyc);
      end
      if (k == 0) fcnt_model = fcnt_model + 32'd1;
    end
    rom_req[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    obi_req = '0;
    for (int k = 0; k < 3; k++) begin
      rom_req[k]  = 1'b0;
      rom_addr[k] = 16'h0000;
    end
    clear_model();
    repeat (3) step();
    tests++;
    if (rom_valid[0] !== 1'b0 || rom_data[0] !== 32'd0) begin
      failed++;
      $display("FAIL reset_rom: got valid=%b data=%h exp 0/0", rom_valid[0], rom_data[0]);
    end
    tests++;
    if (rsp0.rvalid !== 1'b0 || rsp0.rdata !== 32'd0 || rsp0.err !== 1'b0) begin
      failed++;
      $display("FAIL reset_obi: got rvalid=%b rdata=%h err=%b exp 0", rsp0.rvalid, rsp0.rdata, rsp0.err);
    end
    obi_req.req = 1'b1;
    #1;
    tests++;
    if (rsp0.gnt !== 1'b1) begin
      failed++;
      $display("FAIL reset_gnt_high: got %b exp 1", rsp0.gnt);
    end
    step();
    tests++;
    if (rsp0.rvalid !== 1'b0) begin
      failed++;
      $display("FAIL reset_rvalid_held: got %b exp 0", rsp0.rvalid);
    end
    obi_req.req = 1'b0;
    #1;
    tests++;
    if (rsp0.gnt !== 1'b0) begin
      failed++;
      $display("FAIL reset_gnt_low: got %b exp 0", rsp0.gnt);
    end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_obi_regs();
    obi_xfer(1'b0, 32'h100, 4'hF, 32'h0, "ctrl_rd_reset");
    obi_xfer(1'b0, 32'h108, 4'hF, 32'h0, "bad_rd");
    obi_xfer(1'b1, 32'h10C, 4'hF, 32'hDEAD_BEEF, "bad_wr");
    obi_xfer(1'b0, 32'h104, 4'hF, 32'h0, "cnt_rd_reset");
  endtask

  task automatic test_fetch_basic();
    obi_xfer(1'b1, 32'h010, 4'hF, 32'h0403_0201, "wr_word_10");
    obi_xfer(1'b0, 32'h010, 4'hF, 32'h0, "rd_word_10");
    do_fetch(0, 16'h0012, 1, 1'b0, "fetch_12_l1");
    step();
    obi_xfer(1'b1, 32'h0FC, 4'b1000, 32'h5A00_0000, "wr_byte_ff");
    do_fetch(0, 16'h00FF, 1, 1'b0, "fetch_last_pixel");
    step();
    do_fetch(0, 16'h0100, 1, 1'b0, "fetch_first_oob");
    step();
  endtask

  task automatic test_latency();
    do_fetch(1, 16'hFFEF, 3, 1'b0, "fetch_wrap_l3");
    step();
    do_fetch(1, 16'h0011, 3, 1'b1, "fetch_req_drop_l3");
    step();
    do_fetch(2, 16'h0013, 4, 1'b0, "fetch_13_l4");
    step();
  endtask

  task automatic test_lock();
    obi_xfer(1'b1, 32'h100, 4'h1, 32'h1, "ctrl_lock");
    obi_xfer(1'b0, 32'h100, 4'hF, 32'h0, "ctrl_rd_locked");
    obi_xfer(1'b1, 32'h020, 4'h1, 32'h0000_00FF, "wr_locked");
    do_fetch(0, 16'h0020, 1, 1'b0, "fetch_after_locked_wr");
    step();
    obi_xfer(1'b1, 32'h100, 4'h1, 32'h0, "ctrl_unlock");
    obi_xfer(1'b1, 32'h020, 4'h1, 32'h0000_00FF, "wr_unlocked");
    do_fetch(0, 16'h0020, 1, 1'b0, "fetch_after_unlocked_wr");
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] win [9];
    int          idx;
    idx = 0;
    for (int r = -1; r <= 1; r++) begin
      for (int c = -1; c <= 1; c++) begin
        win[idx] = 16'(32'h22 + 16 * r + c);
        idx++;
      end
    end
    for (int i = 0; i < 9; i++) do_fetch(0, win[i], (i == 0) ? 1 : 2, 1'b0, $sformatf("b2b_%0d", i));
    step();
    tests++;
    if (rom_valid[0] !== 1'b0 || rom_data[0] !== 32'd0) begin
      failed++;
      $display("FAIL b2b_idle_after: got valid=%b data=%h exp 0/0", rom_valid[0], rom_data[0]);
    end
    obi_xfer(1'b0, 32'h104, 4'hF, 32'h0, "fetch_cnt_rd");
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    rom_req[2]  = 1'b1;
    rom_addr[2] = 16'h0012;
    step();
    step();
    rst_i      = 1'b1;
    rom_req[2] = 1'b0;
    step();
    rst_i = 1'b0;
    clear_model();
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rom_valid[2] !== 1'b0) seen = 1'b1;
      step();
    end
    tests++;
    if (seen) begin
      failed++;
      $display("FAIL reset_mid_fetch: got valid pulse after reset exp none");
    end
    obi_xfer(1'b0, 32'h010, 4'hF, 32'h0, "mem_after_reset");
    obi_xfer(1'b0, 32'h104, 4'hF, 32'h0, "cnt_after_reset");
  endtask

  task automatic test_write_during_fetch();
    fork
      do_fetch(0, 16'h0005, 1, 1'b0, "fetch_5_same_cycle");
      obi_xfer(1'b1, 32'h004, 4'b0010, 32'h0000_AA00, "wr_5_same_cycle");
    join
    step();
    do_fetch(0, 16'h0005, 1, 1'b0, "fetch_5_after_wr");
    step();
  endtask

  initial begin
    test_reset();
    test_obi_regs();
    test_fetch_basic();
    test_latency();
    test_lock();
    test_back_to_back();
    test_reset_mid_fetch();
    test_write_during_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
